// File: rtl/instr_mem_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the boot loader.
// The master side is the byte source / system controller; the slave side is the loader.
interface instr_mem_loader_if;
    logic        load_start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        cpu_rst_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    modport master (
        output load_start_i, byte_valid_i, byte_data_i,
        input  byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  cpu_rst_o, busy_o, done_o, err_o
    );

    modport slave (
        input  load_start_i, byte_valid_i, byte_data_i,
        output byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output cpu_rst_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader: takes a length-prefixed little-endian
// byte stream, writes one 32-bit word per 4 bytes, checks a trailing XOR
// checksum and keeps the CPU in reset until a load has succeeded.
module instr_mem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic          clk_i,
    input logic          rst_i,
    instr_mem_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    state_t      state, state_n;
    logic [15:0] count;     // announced word count
    logic [15:0] widx;      // index of the next word to be written
    logic [1:0]  bpos;      // byte position inside the word being assembled
    logic [23:0] part;      // low three bytes of the word being assembled
    logic [7:0]  xsum;      // running XOR of all accepted bytes
    logic        ready_q, we_q, busy_q, done_q, err_q, cpu_rst_q;
    logic [31:0] addr_q, wdata_q;

    logic        take;
    logic [15:0] len;
    logic        last_word;

    assign take      = bus.byte_valid_i && ready_q;
    assign len       = {bus.byte_data_i, count[7:0]};
    // widx still holds the index of the word being completed at this point
    assign last_word = ({1'b0, widx} + 17'd1) == {1'b0, count};

    // Next-state decision from the current state and the byte handshake
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERR: if (bus.load_start_i) state_n = LEN0;
            LEN0: if (take) state_n = LEN1;
            LEN1: if (take) begin
                if ({1'b0, len} > DEPTH_L) state_n = ERR;
                else if (len == 16'd0)     state_n = CSUM;
                else                       state_n = DATA;
            end
            DATA: if (take && bpos == 2'd3 && last_word) state_n = CSUM;
            CSUM: if (take) state_n = (bus.byte_data_i == xsum) ? DONE : ERR;
            default: state_n = IDLE;
        endcase
    end

    // State register, state-derived outputs registered on entry, and word datapath
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            count     <= '0;
            widx      <= '0;
            bpos      <= '0;
            part      <= '0;
            xsum      <= '0;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
            addr_q    <= BASE_ADDR;
            wdata_q   <= '0;
        end else begin
            state     <= state_n;
            ready_q   <= state_n inside {LEN0, LEN1, DATA, CSUM};
            busy_q    <= state_n inside {LEN0, LEN1, DATA, CSUM};
            done_q    <= state_n == DONE;
            err_q     <= state_n == ERR;
            cpu_rst_q <= state_n != DONE;
            we_q      <= 1'b0;

            // the write cycle of the final word falls in CSUM, so the index
            // stops at the last written word
            if (we_q && state == DATA) widx <= widx + 16'd1;

            if (state_n == LEN0 && state != LEN0) begin
                xsum <= '0;
                widx <= '0;
                bpos <= '0;
            end

            if (take) begin
                case (state)
                    LEN0: begin
                        count[7:0] <= bus.byte_data_i;
                        xsum       <= xsum ^ bus.byte_data_i;
                    end
                    LEN1: begin
                        count[15:8] <= bus.byte_data_i;
                        xsum        <= xsum ^ bus.byte_data_i;
                    end
                    DATA: begin
                        xsum <= xsum ^ bus.byte_data_i;
                        bpos <= bpos + 2'd1;
                        if (bpos == 2'd3) begin
                            we_q    <= 1'b1;
                            addr_q  <= BASE_ADDR + {14'd0, widx, 2'b00};
                            wdata_q <= {bus.byte_data_i, part};
                        end else begin
                            part[{bpos, 3'b000} +: 8] <= bus.byte_data_i;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.byte_ready_o = ready_q;
    assign bus.mem_we_o     = we_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_wdata_o  = wdata_q;
    assign bus.cpu_rst_o    = cpu_rst_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed plus randomized bench for instr_mem_loader. Expected writes and
// final status come from a stream-level model: the stream is built from a word
// list, the checksum is the XOR of the preceding bytes, and word i lands at
// BASE + 4*i.
module tb_instr_mem_loader;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_mem_loader_if bus();

    instr_mem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    logic [7:0]  stim_q[$];
    logic [31:0] words_q[$];
    bit          exp_done, exp_err;

    // record every write strobe as {addr, data}
    always @(negedge clk)
        if (bus.mem_we_o) obs_q.push_back({bus.mem_addr_o, bus.mem_wdata_o});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock, then verify the write strobe matches what the last edge implies
    task automatic tick(input bit we_exp);
        @(posedge clk);
        @(negedge clk);
        check("mem_we_timing", 64'(bus.mem_we_o), 64'(we_exp));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_rst"}, 64'(bus.cpu_rst_o), 64'd1);
        check({tag, "_ready"},   64'(bus.byte_ready_o), 64'd0);
        check({tag, "_we"},      64'(bus.mem_we_o), 64'd0);
        check({tag, "_busy"},    64'(bus.busy_o), 64'd0);
        check({tag, "_done"},    64'(bus.done_o), 64'd0);
        check({tag, "_err"},     64'(bus.err_o), 64'd0);
        check({tag, "_addr"},    64'(bus.mem_addr_o), 64'(BASE));
        check({tag, "_wdata"},   64'(bus.mem_wdata_o), 64'd0);
    endtask

    // reference model: stream bytes, expected writes and final status
    task automatic build(input int n, input logic [7:0] flip);
        logic [15:0] n16;
        logic [7:0]  x;
        logic [31:0] w;
        n16 = 16'(n);
        stim_q.delete();
        exp_q.delete();
        stim_q.push_back(n16[7:0]);
        stim_q.push_back(n16[15:8]);
        if (n > DEPTH) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = words_q[i];
            for (int k = 0; k < 4; k++) stim_q.push_back(w[8*k +: 8]);
            exp_q.push_back({BASE + 32'(4 * i), w});
        end
        x = 8'h00;
        foreach (stim_q[i]) x = x ^ stim_q[i];
        stim_q.push_back(x ^ flip);
        exp_done = (flip == 8'h00);
        exp_err  = (flip != 8'h00);
    endtask

    function automatic bit word_end(input int idx, input int n);
        return idx >= 2 && idx < 2 + 4 * n && ((idx - 2) % 4) == 3;
    endfunction

    function automatic int gap_for(input int mode, input int idx);
        case (mode)
            1:       return (idx == 0 ? 0 : 1) + (idx == 4 ? 3 : 0);
            2:       return int'($urandom_range(0, 2));
            default: return 0;
        endcase
    endfunction

    task automatic rand_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    // send stim_q[first..last]; optionally hold load_start high (must be ignored)
    task automatic send(input int n, input int first, input int last,
                        input int mode, input bit hold, output bit ok);
        bit hs, we_exp;
        int budget;
        ok = 1'b1;
        for (int idx = first; idx <= last; idx++) begin
            bus.byte_valid_i = 1'b0;
            bus.load_start_i = hold && (idx != stim_q.size() - 1);
            repeat (gap_for(mode, idx)) tick(1'b0);
            bus.byte_valid_i = 1'b1;
            bus.byte_data_i  = stim_q[idx];
            hs = 1'b0;
            budget = 50;
            while (!hs && budget > 0) begin
                hs = bus.byte_ready_o;
                we_exp = hs && word_end(idx, n);
                tick(we_exp);
                budget--;
            end
            if (!hs) begin
                check("byte_accept_timeout", 64'd0, 64'd1);
                ok = 1'b0;
                break;
            end
        end
        bus.byte_valid_i = 1'b0;
        bus.load_start_i = 1'b0;
    endtask

    task automatic start_load();
        bus.load_start_i = 1'b1;
        tick(1'b0);
        bus.load_start_i = 1'b0;
        check("start_ready", 64'(bus.byte_ready_o), 64'd1);
        check("start_busy",  64'(bus.busy_o), 64'd1);
    endtask

    task automatic check_writes();
        int m;
        check("write_count", 64'(obs_q.size()), 64'(exp_q.size()));
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check("write_addr_data", obs_q[i], exp_q[i]);
    endtask

    task automatic run_load(input int n, input logic [7:0] flip, input int mode, input bit hold);
        bit ok;
        build(n, flip);
        obs_q.delete();
        start_load();
        send(n, 0, stim_q.size() - 1, mode, hold, ok);
        check("end_done",    64'(bus.done_o), 64'(exp_done));
        check("end_err",     64'(bus.err_o), 64'(exp_err));
        check("end_cpu_rst", 64'(bus.cpu_rst_o), 64'(!exp_done));
        check("end_busy",    64'(bus.busy_o), 64'd0);
        check("end_ready",   64'(bus.byte_ready_o), 64'd0);
        check_writes();
    endtask

    initial begin
        bit ok;
        int n;
        logic [7:0] flip;
        bus.load_start_i = 1'b0;
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i  = 8'h00;

        // reset state, during and just after reset
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;
        tick(1'b0);
        check_reset_vals("idle");

        // nominal two-word program
        words_q = '{32'h0050_0093, 32'h00A0_0113};
        run_load(2, 8'h00, 0, 1'b0);

        // checksum off by one bit (0x72), then a good reload from ERR
        run_load(2, 8'h01, 0, 1'b0);
        run_load(2, 8'h00, 0, 1'b0);

        // count of DEPTH+1 is rejected after the second byte
        rand_words(0);
        run_load(DEPTH + 1, 8'h00, 0, 1'b0);
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i  = 8'h5A;
        repeat (4) begin
            tick(1'b0);
            check("err_no_ready", 64'(bus.byte_ready_o), 64'd0);
        end
        bus.byte_valid_i = 1'b0;
        check("err_no_writes", 64'(obs_q.size()), 64'd0);

        // empty program
        run_load(0, 8'h00, 0, 1'b0);

        // backpressure: alternate-cycle valid with a 3-cycle stall mid-word
        words_q = '{32'h0050_0093, 32'h00A0_0113};
        run_load(2, 8'h00, 1, 1'b0);

        // randomized programs, gaps, ignored load_start, occasional bad checksum
        repeat (12) begin
            n = int'($urandom_range(1, 8));
            rand_words(n);
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_load(n, flip, 2, 1'($urandom_range(0, 1)));
        end

        // full-capacity program
        rand_words(DEPTH);
        run_load(DEPTH, 8'h00, 0, 1'b0);

        // reset after the 6th byte of the nominal stream
        words_q = '{32'h0050_0093, 32'h00A0_0113};
        build(2, 8'h00);
        obs_q.delete();
        start_load();
        send(2, 0, 5, 0, 1'b0, ok);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        check("midrst_partial_writes", 64'(obs_q.size()), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick(1'b0);
        tick(1'b0);
        check("midrst_no_more_writes", 64'(obs_q.size()), 64'd1);
        check_reset_vals("postrst");
        run_load(2, 8'h00, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time program loader that writes the instruction memory the single-cycle CPU fetches from. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one write per word into the instruction memory. It verifies a trailing XOR checksum and holds the CPU in reset until a load completes successfully.

## Interface

- `DEPTH_WORDS`, default 256: instruction-memory capacity in words; maximum accepted word count.
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first word written.
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous and active-high.
- `load_start_i` input 1: begins a load; sampled only in IDLE, DONE or ERR.
- `byte_valid_i` input 1: source has a byte on `byte_data_i`.
- `byte_data_i` input 8: stream byte.
- `byte_ready_o` output 1: loader accepts a byte this cycle.
- `mem_we_o` output 1: one-cycle instruction-memory write strobe.
- `mem_addr_o` output 32: byte address of the write (word aligned).
- `mem_wdata_o` output 32: instruction word.
- `cpu_rst_o` output 1: reset to the CPU; high while not DONE.
- `busy_o` output 1: a load is in progress (LEN0, LEN1, DATA or CSUM).
- `done_o` output 1: last load succeeded.
- `err_o` output 1: last load failed (bad length or checksum).

## Operation

- A byte transfers on a rising edge where `byte_valid_i && byte_ready_o`. `byte_ready_o` = 1 in LEN0, LEN1, DATA and CSUM, and 0 otherwise. It is a pure function of state.
- Stream format, in order:
  - count N as 2 bytes, little-endian (low byte first);
  - N words, each as 4 bytes, little-endian;
  - 1 checksum byte, equal to the XOR of every preceding byte (length bytes included).
- The running XOR clears on entry to LEN0.
- States:
  - IDLE: entered from reset. `load_start_i` → LEN0.
  - LEN0: accept the low count byte → LEN1.
  - LEN1: accept the high count byte.
    - N > DEPTH_WORDS → ERR.
    - N = 0 → CSUM.
    - Otherwise → DATA.
  - DATA: shift bytes into a 32-bit word, byte k going to bits [8k+7:8k]. On the 4th byte the word is complete and is written.
    - After the Nth word → CSUM.
    - Otherwise stay in DATA, starting a new word.
  - CSUM: accept the checksum byte.
    - Matches the running XOR → DONE.
    - Otherwise → ERR.
  - DONE, ERR: `load_start_i` → LEN0. This clears `done_o` and `err_o` and sets the write index to 0.
- `load_start_i` in LEN0 through CSUM is ignored.
- Write address for word index i is BASE_ADDR + 4·i, with i counting from 0. Width rules:
  - i is 16 bits;
  - the address is computed in 32 bits and wraps modulo 2^32;
  - i never exceeds DEPTH_WORDS−1.
- Outputs by state:
  - `cpu_rst_o` = 1 in every state except DONE.
  - `done_o` = 1 only in DONE; `err_o` = 1 only in ERR.
  - `busy_o` = 1 in LEN0, LEN1, DATA and CSUM.
- Words written before an error are not rolled back. The CPU stays in reset until a later load succeeds.

## Timing

- Reset values (asynchronous, immediate):
  - state = IDLE;
  - `cpu_rst_o` = 1;
  - `byte_ready_o`, `mem_we_o`, `busy_o`, `done_o`, `err_o` = 0;
  - `mem_addr_o` = BASE_ADDR;
  - `mem_wdata_o` = 0.
- Write latency: `mem_we_o` is registered. It is high for exactly one cycle, the cycle after the edge that accepted a word's 4th byte. `mem_addr_o` and `mem_wdata_o` are valid in that same cycle and hold until the next write.
- The write index increments on the edge that ends the write cycle.
- Throughput: one byte per cycle when `byte_valid_i` stays high, giving a sustained rate of one word per 4 cycles. `mem_we_o` may coincide with acceptance of the next byte.
- Gaps in `byte_valid_i` stall the byte position without losing partial-word data.
- State outputs change on the edge that moves into the new state:
  - `cpu_rst_o` falls, and `done_o` rises, in the first cycle after the edge that accepted a matching checksum byte.
- Start latency: `load_start_i` high at edge T gives `byte_ready_o` = 1 in the cycle after T.
- Boundary cases:
  - Reset asserted mid-load aborts immediately, with no further writes. A pending `mem_we_o` is cleared asynchronously.
  - N = DEPTH_WORDS is accepted.
  - N = DEPTH_WORDS + 1 → ERR on the LEN1 handshake, and no DATA bytes are accepted.

## Test plan

- Nominal load with DEPTH_WORDS = 256, stream 02 00 93 00 50 00 13 01 A0 00 73 at one byte per cycle:
  - writes (0x00, 0x00500093) and then (0x04, 0x00A00113), each `mem_we_o` pulse lasting one cycle;
  - afterwards `done_o` = 1 and `cpu_rst_o` = 0, with `err_o` = 0.
- Same stream with a checksum of 0x72:
  - both words are written, then `err_o` = 1, `done_o` = 0 and `cpu_rst_o` stays 1;
  - a following `load_start_i` plus the correct stream reaches DONE.
- Count 01 01 (N = 257) → ERR right after the second byte. `byte_ready_o` = 0 afterwards and no `mem_we_o` is issued.
- Empty load 00 00 00 → DONE with zero writes.
- Backpressure: the nominal stream with `byte_valid_i` low on alternate cycles and 3 idle cycles mid-word produces identical writes and DONE.
- Reset mid-load: assert `rst_i` after the 6th byte of the nominal stream.
  - Immediately, every output holds its reset value and no further writes occur.
  - `load_start_i` plus the full stream then writes at 0x00 and 0x04 again and reaches DONE.
